// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: two-flop RXD synchroniser, centre-sampling FSM and a
// one-entry valid/ready holding register with framing-error and overrun flags.
module uart_rx_8n1 #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       RXD,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  output logic       rx_busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_sync1;
  logic            r_sync2;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_idx;
  logic [7:0]      r_shift;
  logic [7:0]      r_data;
  logic            r_valid;
  logic            r_ferr;
  logic            r_ovr;

  logic            w_rxs;
  logic            w_cnt_end;
  logic            w_cnt_half;
  logic            w_cnt_clr;
  logic            w_sample;
  logic            w_good;
  logic            w_ferr;
  logic            w_hs;

  assign w_rxs      = r_sync2;
  assign w_cnt_end  = (r_cnt == CW'(CLKS_PER_BIT - 1));
  assign w_cnt_half = (r_cnt == CW'(HALF - 1));
  assign w_hs       = r_valid & rx_ready;

  // RXD is asynchronous; the synchroniser idles high so reset never looks like a start bit
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= RXD;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_sample    = 1'b0;
    w_good      = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_clr = 1'b1;
        if (!w_rxs) w_state_nxt = S_START;
      end
      S_START: begin
        // a start bit that is gone by mid-bit is a glitch
        if (w_cnt_half) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = w_rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_cnt_end) begin
          w_cnt_clr = 1'b1;
          w_sample  = 1'b1;
          if (r_idx == 3'd7) w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        // returning to IDLE at stop-bit centre leaves half a bit to catch the next start
        if (w_cnt_end) begin
          w_cnt_clr = 1'b1;
          if (w_rxs) begin
            w_good      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        w_cnt_clr = 1'b1;
        if (w_rxs) w_state_nxt = S_IDLE;
      end
      default: begin
        w_cnt_clr   = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_cnt <= w_cnt_clr ? '0 : r_cnt + CW'(1);
      if (r_state != S_DATA) r_idx <= '0;
      else if (w_sample)     r_idx <= r_idx + 3'd1;
      if (w_sample) r_shift[r_idx] <= w_rxs;
    end
  end

  // Holding register: a consume in the load cycle frees the slot for the new byte
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= w_ferr;
      if (w_good && (!r_valid || w_hs)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (w_hs) begin
        r_valid <= 1'b0;
      end
      if (w_good && r_valid && !w_hs) r_ovr <= 1'b1;
      else if (w_hs)                  r_ovr <= 1'b0;
    end
  end

  assign rx_data      = r_data;
  assign rx_valid     = r_valid;
  assign rx_frame_err = r_ferr;
  assign rx_overrun   = r_ovr;
  assign rx_busy      = (r_state != S_IDLE);

endmodule
